// File: rtl/std_div_arbiter.sv
// Shared unsigned divider with a round-robin arbiter in front of it.
// std_div_pipe is a bit-serial restoring divider that starts on go and
// clears whenever go drops. std_div_arbiter grants one requester at a time,
// latches that requester's operands, and either runs the divider or takes
// the divide-by-zero shortcut.

module std_div_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             active_q;
  logic             done_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and try subtracting the divisor; bit WIDTH of the trial is the borrow.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
  end

  // Load on the first go cycle, iterate WIDTH steps, then hold done until
  // go drops. A zero dividend finishes immediately with zero results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else if (!go) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else if (active_q) begin
      if (trial[WIDTH]) begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
      if (count_q == CW'(WIDTH - 1)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
      count_q <= count_q + 1'b1;
    end else if (!done_q) begin
      quo_q   <= dividend;
      rem_q   <= '0;
      count_q <= '0;
      if (dividend == '0) begin
        done_q <= 1'b1;
      end else begin
        active_q <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

module std_div_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] left,
  input  logic [NREQ*WIDTH-1:0] right,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      out_quotient,
  output logic [WIDTH-1:0]      out_remainder,
  output logic                  div_by_zero,
  output logic [IDW-1:0]        owner,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic [IDW-1:0]   owner_q,      owner_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0] opa_q,        opa_d;
  logic [WIDTH-1:0] opb_q,        opb_d;
  logic [NREQ-1:0]  ack_q,        ack_d;
  logic [WIDTH-1:0] quo_out_q,    quo_out_d;
  logic [WIDTH-1:0] rem_out_q,    rem_out_d;
  logic             dbz_q,        dbz_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW:0]      ptr;
  logic [IDW:0]      sum;
  logic              grant_valid;
  logic [IDW-1:0]    grant_idx;
  logic [WIDTH-1:0]  grant_left;
  logic [WIDTH-1:0]  grant_right;
  logic [NREQ-1:0]   owner_dec;
  logic [NREQ-1:0]   grant_dec;
  logic              req_owner;

  logic             div_go;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Rotate the request vector so bit 0 is the requester after last_grant;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_dbl     = {req, req};
    ptr         = {1'b0, last_grant_q} + 1'b1;
    req_rot     = req_dbl[ptr +: NREQ];
    grant_valid = 1'b0;
    sum         = '0;
    grant_idx   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        grant_valid = 1'b1;
        sum         = ptr + (IDW+1)'(j);
      end
    end
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end
    grant_idx   = sum[IDW-1:0];
    grant_left  = left[grant_idx*WIDTH +: WIDTH];
    grant_right = right[grant_idx*WIDTH +: WIDTH];
    req_owner   = req[owner_q];
  end

  // One-hot decodes of the current owner and of the pending winner.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
      assign owner_dec[gi] = (owner_q == IDW'(gi));
      assign grant_dec[gi] = (grant_idx == IDW'(gi));
    end
  endgenerate

  // Next-state logic for the FSM, grant bookkeeping and result registers.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    ack_d        = '0;
    quo_out_d    = quo_out_q;
    rem_out_d    = rem_out_q;
    dbz_d        = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          opa_d        = grant_left;
          opb_d        = grant_right;
          if (grant_right == '0) begin
            // Zero divisor: answer straight away without touching the divider.
            state_d   = ST_FLUSH;
            quo_out_d = '1;
            rem_out_d = grant_left;
            dbz_d     = 1'b1;
            ack_d     = grant_dec;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!req_owner) begin
          // Requester withdrew: abandon the divide, keep the old results.
          state_d = ST_FLUSH;
        end else if (div_done) begin
          state_d   = ST_FLUSH;
          quo_out_d = div_quo;
          rem_out_d = div_rem;
          dbz_d     = 1'b0;
          ack_d     = owner_dec;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to NREQ-1 so requester 0 goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      opa_q        <= '0;
      opb_q        <= '0;
      ack_q        <= '0;
      quo_out_q    <= '0;
      rem_out_q    <= '0;
      dbz_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      ack_q        <= ack_d;
      quo_out_q    <= quo_out_d;
      rem_out_q    <= rem_out_d;
      dbz_q        <= dbz_d;
    end
  end

  // The divider only ever sees latched operands and runs only in RUN, so
  // leaving RUN for any reason clears it before the next divide.
  assign div_go = (state_q == ST_RUN);

  std_div_pipe #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (div_go),
    .dividend  (opa_q),
    .divisor   (opb_q),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign ack           = ack_q;
  assign out_quotient  = quo_out_q;
  assign out_remainder = rem_out_q;
  assign div_by_zero   = dbz_q;
  assign owner         = owner_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/std_div_arbiter.md
STD_DIV_ARBITER -- requirements
Module: std_div_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter IDW, default $clog2(NREQ): width of the requester index.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 req  input  NREQ: req[i] high requests one divide and is held until ack[i] or withdrawal.
REQ-007 left  input  NREQ*WIDTH: dividend for requester i in bits [i*WIDTH +: WIDTH], unsigned.
REQ-008 right  input  NREQ*WIDTH: divisor for requester i in bits [i*WIDTH +: WIDTH], unsigned.
REQ-009 ack  output  NREQ: one-cycle pulse on ack[i] when the result for requester i is valid.
REQ-010 out_quotient  output  WIDTH: registered quotient of the most recent acked divide.
REQ-011 out_remainder  output  WIDTH: registered remainder of the most recent acked divide.
REQ-012 div_by_zero  output  1: high with the most recent acked result if its divisor was 0.
REQ-013 owner  output  IDW: index of the requester currently granted, or the last one granted.
REQ-014 busy  output  1: high in every state except IDLE.

Function
REQ-015 The block SHALL share one std_div_pipe instance of width WIDTH among all requesters, one divide at a time.
REQ-016 FSM states: IDLE, RUN, FLUSH. IDLE -> RUN on grant with right != 0. IDLE -> FLUSH on grant with right == 0. RUN -> FLUSH on divider done or on withdrawal. FLUSH -> IDLE unconditionally.
REQ-017 Arbitration in IDLE: round-robin; search starts at (last_grant+1) mod NREQ; the first index with req high wins.
REQ-018 On grant, the block latches the winner index into owner and last_grant, and latches that requester's left and right into internal operand registers.
REQ-019 The divider SHALL see only the latched operands; operand changes after the grant are ignored.
REQ-020 The divider go input SHALL be high exactly while the FSM is in RUN; it is low in IDLE and FLUSH, so each divide starts from a cleared divider.
REQ-021 On divider done in RUN: out_quotient and out_remainder load the divider results, div_by_zero loads 0, and ack[owner] pulses in that cycle.
REQ-022 Divide-by-zero bypass: when right == 0 at grant, the divider is not started. On the grant edge, out_quotient loads all-ones, out_remainder loads left, and div_by_zero loads 1. ack[owner] pulses in the following FLUSH cycle.
REQ-023 left == 0 with right != 0 produces quotient 0 and remainder 0 through the divider early-done path.
REQ-024 Latency: ack SHALL occur within WIDTH+4 cycles after the grant edge for a nonzero divisor, and exactly 1 cycle after it for a zero divisor.
REQ-025 Withdrawal: if req[owner] goes low while in RUN, the divide is aborted and the FSM goes to FLUSH. No ack is produced and the output registers keep their previous values.
REQ-026 A req[i] still high in IDLE after its ack is treated as a new request; other pending requesters take priority under round-robin.
REQ-027 ack SHALL be one-hot or zero in every cycle.
REQ-028 out_quotient, out_remainder and div_by_zero SHALL change only in a cycle in which an ack is issued.

Reset
REQ-029 While reset_n is low, the block SHALL be in the following state, asynchronously: FSM = IDLE, ack = 0, busy = 0, out_quotient = 0, out_remainder = 0, div_by_zero = 0, owner = 0, last_grant = NREQ-1 (so requester 0 has first priority), divider go = 0.
REQ-030 Reset asserted mid-divide aborts it with no ack. The first grant after reset release is evaluated in the first IDLE cycle.

Verification
REQ-031 Only req[0], left0=100, right0=7 -> exactly one ack[0]; out_quotient=14, out_remainder=2, div_by_zero=0, owner=0; ack within WIDTH+4 cycles.
REQ-032 After reset, req=4'b1111 held, with operand i set to left=1000+i, right=3 -> acks in order 0,1,2,3, each with the correct quotient and remainder, never two acks in one cycle.
REQ-033 req[2], left2=55, right2=0 -> ack[2] exactly 1 cycle after the grant edge; out_quotient=32'hFFFFFFFF, out_remainder=55, div_by_zero=1.
REQ-034 req[1] granted (left1=9, right1=2), req[1] dropped 5 cycles into RUN while req[3] (left3=20, right3=6) is pending -> no ack[1], outputs unchanged; then ack[3] with out_quotient=3, out_remainder=2.
REQ-035 reset_n pulsed low mid-RUN -> all outputs 0 immediately with no ack; after release, req[0] with 17/5 -> out_quotient=3, out_remainder=2.
REQ-036 req[0] with left0=0, right0=9 -> ack[0]; out_quotient=0, out_remainder=0, div_by_zero=0.
